// File: rtl/fir_coef_pkg.sv
// rtl/fir_coef_pkg.sv - shared types and frame sizing for the FIR coefficient loader
// FIR_COEF_CHECKSUM_EN adds a trailing checksum word to every frame.
package fir_coef_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, PEND, DRAIN} loader_state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_SHORT, ERR_LONG, ERR_CSUM} coef_err_t;

  function automatic int frame_len(input int n_taps);
`ifdef FIR_COEF_CHECKSUM_EN
    return n_taps + 1;
`else
    return n_taps;
`endif
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - shadow coefficient bank with single-cycle copy into the active bank
// Reset clears both banks so a half-written shadow never reaches the filter.
module fir_coef_bank
  import fir_coef_pkg::*;
#(
  parameter int N_TAPS     = 8,
  parameter int COEF_WIDTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_we,
  input  logic [$clog2(N_TAPS)-1:0]    i_addr,
  input  logic [COEF_WIDTH-1:0]        i_data,
  input  logic                         i_commit,
  output logic [N_TAPS*COEF_WIDTH-1:0] o_coef
);

  logic [COEF_WIDTH-1:0]        r_shadow [N_TAPS];
  logic [N_TAPS*COEF_WIDTH-1:0] r_active;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N_TAPS; i++) r_shadow[i] <= '0;
      r_active <= '0;
    end else begin
      if (i_we) r_shadow[i_addr] <= i_data;
      if (i_commit) begin
        for (int i = 0; i < N_TAPS; i++) r_active[i*COEF_WIDTH +: COEF_WIDTH] <= r_shadow[i];
      end
    end
  end

  assign o_coef = r_active;

endmodule

// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - coefficient frame loader: length/checksum validation and gated bank swap
// Optional trailing-checksum support is enabled by FIR_COEF_CHECKSUM_EN.
module fir_coef_loader
  import fir_coef_pkg::*;
#(
  parameter int N_TAPS     = 8,
  parameter int COEF_WIDTH = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_s_valid,
  output logic                         o_s_ready,
  input  logic [COEF_WIDTH-1:0]        i_s_data,
  input  logic                         i_s_last,
  input  logic                         i_swap_en,
  output logic [N_TAPS*COEF_WIDTH-1:0] o_coef_out,
  output logic                         o_coef_update,
  output logic                         o_busy,
  output logic                         o_err_valid,
  output logic [1:0]                   o_err_code
);

  localparam int FRAME_LEN = frame_len(N_TAPS);
  localparam int CNT_W     = $clog2(N_TAPS + 2);
  localparam int AW        = $clog2(N_TAPS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] TAPS_IDX = CNT_W'(N_TAPS);
  localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(FRAME_LEN);

  loader_state_t    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_coef_update;
  logic             r_err_valid;
  coef_err_t        r_err_code;
  coef_err_t        w_err;
  logic             w_xfer;
  logic             w_we;
  logic             w_commit;
  logic             w_csum_ok;

  assign o_s_ready = (r_state != PEND);
  assign w_xfer    = i_s_valid & o_s_ready;
  // The checksum word (index N_TAPS) is compared, never stored.
  assign w_we      = w_xfer && ((r_state == IDLE) || ((r_state == LOAD) && (r_count < TAPS_IDX)));

`ifdef FIR_COEF_CHECKSUM_EN
  logic [COEF_WIDTH-1:0] r_sum;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum <= '0;
    end else if (w_xfer && (r_state == IDLE)) begin
      r_sum <= i_s_data;
    end else if (w_we) begin
      r_sum <= r_sum + i_s_data;
    end
  end

  assign w_csum_ok = (i_s_data == r_sum);
`else
  assign w_csum_ok = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_commit    = 1'b0;
    w_err       = ERR_NONE;
    unique case (r_state)
      IDLE: begin
        if (w_xfer) begin
          if (i_s_last) begin
            w_err = ERR_SHORT;
          end else begin
            w_state_nxt = LOAD;
            w_count_nxt = CNT_W'(1);
          end
        end
      end
      LOAD: begin
        if (w_xfer) begin
          if (r_count == LAST_IDX) begin
            if (!i_s_last) begin
              w_state_nxt = DRAIN;
              w_count_nxt = SAT_CNT;
            end else if (w_csum_ok) begin
              w_state_nxt = PEND;
              w_count_nxt = '0;
            end else begin
              w_err       = ERR_CSUM;
              w_state_nxt = IDLE;
              w_count_nxt = '0;
            end
          end else if (i_s_last) begin
            w_err       = ERR_SHORT;
            w_state_nxt = IDLE;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end
      end
      PEND: begin
        if (i_swap_en) begin
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end
      end
      DRAIN: begin
        if (w_xfer && i_s_last) begin
          w_err       = ERR_LONG;
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_coef_update <= 1'b0;
      r_err_valid   <= 1'b0;
      r_err_code    <= ERR_NONE;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_coef_update <= w_commit;
      r_err_valid   <= (w_err != ERR_NONE);
      if (w_err != ERR_NONE) r_err_code <= w_err;
    end
  end

  fir_coef_bank #(
    .N_TAPS     (N_TAPS),
    .COEF_WIDTH (COEF_WIDTH)
  ) u_bank (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (w_we),
    .i_addr   (r_count[AW-1:0]),
    .i_data   (i_s_data),
    .i_commit (w_commit),
    .o_coef   (o_coef_out)
  );

  assign o_coef_update = r_coef_update;
  assign o_busy        = (r_state != IDLE);
  assign o_err_valid   = r_err_valid;
  assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb/tb_fir_coef_loader.sv - scoreboard bench for fir_coef_loader (honours FIR_COEF_CHECKSUM_EN)
module tb_fir_coef_loader;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int BW = N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          swap_en = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready;
  logic [BW-1:0] coef_out;
  logic          coef_update;
  logic          busy;
  logic          err_valid;
  logic [1:0]    err_code;

  fir_coef_loader #(.N_TAPS(N), .COEF_WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_s_valid     (s_valid),
    .o_s_ready     (s_ready),
    .i_s_data      (s_data),
    .i_s_last      (s_last),
    .i_swap_en     (swap_en),
    .o_coef_out    (coef_out),
    .o_coef_update (coef_update),
    .o_busy        (busy),
    .o_err_valid   (err_valid),
    .o_err_code    (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [1:0]    code;
    logic [BW-1:0] bank;
  } ev_t;

  ev_t           sb[$];
  ev_t           mon_e;
  int            n_vec  = 0;
  int            n_fail = 0;
  logic [BW-1:0] exp_bank = '0;
  logic [BW-1:0] old_bank;
  logic [W-1:0]  f[$];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack(input logic [W-1:0] w[$]);
    logic [BW-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = w[i];
    return r;
  endfunction

  task automatic push_commit(input logic [BW-1:0] bank);
    sb.push_back('{1'b0, 2'b00, bank});
    exp_bank = bank;
  endtask

  task automatic push_err(input logic [1:0] code);
    sb.push_back('{1'b1, code, exp_bank});
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic last, input bit gaps);
    int t = 0;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      s_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) check("ready_timeout", {127'd0, s_ready}, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] w[$], input bit gaps);
    for (int i = 0; i < w.size(); i++) send_word(w[i], (i == w.size() - 1), gaps);
  endtask

  // Appends the trailing checksum word when the checksum build is selected.
  task automatic send_good(input logic [W-1:0] w[$], input bit gaps);
    logic [W-1:0] q[$];
    logic [W-1:0] s = '0;
    q = w;
`ifdef FIR_COEF_CHECKSUM_EN
    for (int i = 0; i < N; i++) s = s + w[i];
    q.push_back(s);
`endif
    send_frame(q, gaps);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (coef_update || err_valid)) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {126'd0, err_valid, coef_update}, 0);
        end else begin
          mon_e = sb.pop_front();
          check("event_kind", {126'd0, err_valid, coef_update}, mon_e.is_err ? 2'b10 : 2'b01);
          if (mon_e.is_err) check("err_code", {126'd0, err_code}, {126'd0, mon_e.code});
          check("coef_out_at_event", coef_out, mon_e.bank);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", {127'd0, s_ready}, 1);
    check("rst_busy", {127'd0, busy}, 0);
    check("rst_coef_out", coef_out, 0);
    check("rst_err_valid", {127'd0, err_valid}, 0);
    check("rst_coef_update", {127'd0, coef_update}, 0);
    check("rst_err_code", {126'd0, err_code}, 0);
    @(posedge clk);
    #1;

    swap_en = 1'b1;
    f = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
    push_commit(128'h0008_0007_0006_0005_0004_0003_0002_0001);
    send_good(f, 0);
    @(negedge clk);
    check("pend_busy", {127'd0, busy}, 1);
    check("pend_coef_old", coef_out, 0);
    check("pend_no_update", {127'd0, coef_update}, 0);
    @(negedge clk);
    check("min_latency_update", {127'd0, coef_update}, 1);
    check("commit_busy", {127'd0, busy}, 0);
    idle(2);

    swap_en  = 1'b0;
    old_bank = exp_bank;
    f = '{16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015, 16'h0016, 16'h0017, 16'h0018};
    push_commit(pack(f));
    send_good(f, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_s_ready", {127'd0, s_ready}, 0);
      check("hold_coef_out", coef_out, old_bank);
    end
    @(posedge clk);
    #1;
    swap_en = 1'b1;
    idle(3);
    check("gated_commit_bank", coef_out, 128'h0018_0017_0016_0015_0014_0013_0012_0011);

    f = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 16'h00A5};
    push_err(2'b01);
    send_frame(f, 0);
    idle(3);
    f = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107, 16'h0108};
    push_commit(pack(f));
    send_good(f, 0);
    idle(3);

    f = {};
    for (int i = 0; i < 11; i++) f.push_back(16'h0B00 + 16'(i));
    push_err(2'b10);
    send_frame(f, 0);
    idle(3);
    check("after_long_err_code", {126'd0, err_code}, 2);

    f = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
    push_commit(128'h7FFF_8000_7FFF_8000_7FFF_8000_7FFF_8000);
    send_good(f, 1);
    idle(3);

    for (int i = 0; i < 4; i++) send_word(16'h5550 + 16'(i), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_bank = '0;
    @(negedge clk);
    check("midrst_coef_out", coef_out, 0);
    check("midrst_busy", {127'd0, busy}, 0);
    check("midrst_err_valid", {127'd0, err_valid}, 0);
    check("midrst_s_ready", {127'd0, s_ready}, 1);
    idle(2);

`ifdef FIR_COEF_CHECKSUM_EN
    f = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0025};
    push_err(2'b11);
    send_frame(f, 0);
    idle(3);
    f = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0024};
    push_commit(128'h0008_0007_0006_0005_0004_0003_0002_0001);
    send_frame(f, 0);
    idle(3);
`else
    f = '{16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04, 16'h0C05, 16'h0C06, 16'h0C07, 16'h0C08};
    push_commit(pack(f));
    send_good(f, 0);
    idle(3);
`endif

    idle(5);
    check("scoreboard_drained", 128'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
